pipe_hazard_ctrl: RTL
=====================

Name: pipe_hazard_ctrl

Overview:
- Front-end sequencer for the pipelined core.
- Drives PC write-enable, the Buffer1 write-enable and the bubble (BB) strobe, plus a bubble into Buffer2.
- Stalls fetch on memory busy and load-use hazards, and blocks fetch while a control-transfer instruction is unresolved.
- Applies the branch redirect when stage 3 resolves it; sits between the decode/execute hazard flags and the PC/Buffer1/Buffer2 registers.

Parameters:
- BR_TIMEOUT, 8: max cycles in BRWAIT before forced exit with error.
- CNT_W, 16: width of the saturating bubble counter.

Ports:
- clk  in  1  core clock
- rst_n  in  1  reset, asynchronous, active-low
- ctrl_s2  in  1  stage 2 holds a branch/jump (decoded from Buffer1 opcode)
- resolve_s3  in  1  stage 3 branch outcome valid this cycle
- taken_s3  in  1  outcome, qualified by resolve_s3
- load_use  in  1  stage 2 depends on a load in stage 3
- mem_busy  in  1  memory not ready; freeze front end
- pc_we  out  1  PC register load enable
- pc_sel  out  1  0 = PC+1, 1 = branch target
- buf1_we  out  1  Buffer1 capture enable
- bb  out  1  Buffer1 loads NOP opcode 8'h00 instead of IR
- bb2  out  1  Buffer2 loads NOP
- err_timeout  out  1  sticky, BRWAIT timeout occurred
- bubble_cnt  out  CNT_W  saturating count of cycles with bb or bb2 high

Behaviour:
- State is registered; outputs are combinational from state, pending registers and current inputs.
- States: RUN, BRWAIT, HOLD.
- Input priority within a cycle: mem_busy > resolve_s3 > ctrl_s2 > load_use.
- Reset (rst_n low, at any time, async):
  - state=RUN, pend_valid=0, pend_taken=0, wait_cnt=0, err_timeout=0, bubble_cnt=0.
  - While rst_n is low, outputs are forced: pc_we=0, buf1_we=0, bb=1, bb2=1, pc_sel=0.
- RUN:
  - mem_busy: pc_we=0, buf1_we=0, bb=0, bb2=0; next HOLD.
  - ctrl_s2: pc_we=0, buf1_we=1, bb=1 (the speculative fetch is squashed); next BRWAIT, wait_cnt<=0.
  - load_use: pc_we=0, buf1_we=0 (Buffer1 holds), bb2=1; stay RUN. Repeats each cycle load_use stays high.
  - Otherwise: pc_we=1, pc_sel=0, buf1_we=1, bb=0, bb2=0.
- BRWAIT:
  - Default each cycle: pc_we=0, buf1_we=1, bb=1; wait_cnt increments.
  - resolve_s3 and !mem_busy: pc_we=1, pc_sel=taken_s3, bb=1; next RUN.
  - resolve_s3 and mem_busy: pc_we=0; pend_valid<=1, pend_taken<=taken_s3; next HOLD.
  - mem_busy without resolve: stay BRWAIT, pc_we=0, buf1_we=0, bb=0; wait_cnt holds.
  - wait_cnt==BR_TIMEOUT-1 without resolve: err_timeout<=1, pc_we=1, pc_sel=0; next RUN.
  - ctrl_s2 and load_use are ignored in BRWAIT.
- HOLD:
  - While mem_busy: pc_we=0, buf1_we=0, bb=0, bb2=0.
  - On mem_busy low with pend_valid: pc_we=1, pc_sel=pend_taken, buf1_we=1, bb=1; pend_valid<=0; next RUN.
  - On mem_busy low without pend_valid: next RUN. Outputs follow the RUN rules that same cycle; zero-bubble exit.
- bubble_cnt:
  - Increments by 1 in any cycle with (bb|bb2) and rst_n high.
  - Saturates at all-ones; never wraps.
- err_timeout clears only on reset.

Decomposition:
- Package pipe_ctrl_pkg: state enum {RUN, BRWAIT, HOLD}, NOP_OPCODE=8'h00, default BR_TIMEOUT.
- One sub-module: sat_counter (parameter W; increment enable; async active-low clear), used for bubble_cnt.
- wait_cnt stays inline.

Test Plan:
- Reset release with all inputs 0: first cycle pc_we=1, buf1_we=1, bb=0; bubble_cnt=0.
- Branch taken: ctrl_s2 pulse, resolve_s3=1 and taken_s3=1 two cycles later.
  - Required: bb=1 for 3 cycles, pc_we=0, 0, then 1 with pc_sel=1; back to RUN; bubble_cnt=3.
- load_use held 2 cycles: pc_we=0 and buf1_we=0 for 2 cycles, bb2=1 both, bb=0; bubble_cnt=2.
- resolve_s3 with taken_s3=0 coinciding with mem_busy high for 3 cycles:
  - HOLD for 3 cycles with pc_we=0.
  - Exit cycle: pc_we=1, pc_sel=0, bb=1; pend_valid cleared.
- No resolve for BR_TIMEOUT=8 cycles after ctrl_s2: err_timeout=1 on the 8th cycle, pc_we=1, pc_sel=0; err_timeout stays 1 until reset.
- rst_n asserted mid-BRWAIT: outputs forced to the reset values immediately (async); after release, state=RUN and pend_valid=0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the front-end hazard sequencer.
package pipe_ctrl_pkg;

  // Front-end sequencing states.
  typedef enum logic [1:0] {
    RUN    = 2'd0,
    BRWAIT = 2'd1,
    HOLD   = 2'd2
  } state_t;

  // Opcode Buffer1 captures in place of IR when a bubble is injected.
  localparam logic [7:0] NOP_OPCODE = 8'h00;

  // Default number of cycles a branch may stay unresolved.
  localparam int BR_TIMEOUT_DEF = 8;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with async active-low clear; holds at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] count
);

  // Count enabled cycles, stopping at the maximum value instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Front-end sequencer: PC/Buffer1 enables, bubble strobes, branch wait and memory freeze.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int BR_TIMEOUT = BR_TIMEOUT_DEF,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ctrl_s2,
  input  logic             resolve_s3,
  input  logic             taken_s3,
  input  logic             load_use,
  input  logic             mem_busy,
  output logic             pc_we,
  output logic             pc_sel,
  output logic             buf1_we,
  output logic             bb,
  output logic             bb2,
  output logic             err_timeout,
  output logic [CNT_W-1:0] bubble_cnt
);

  localparam int WAIT_W = $clog2(BR_TIMEOUT) + 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(BR_TIMEOUT - 1);

  state_t              state_q, state_d;
  logic                pend_valid_q, pend_valid_d;
  logic                pend_taken_q, pend_taken_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic                err_d;
  logic                pc_we_c, pc_sel_c, buf1_we_c, bb_c, bb2_c;

  // State, pending-redirect, wait counter and sticky error registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RUN;
      pend_valid_q <= 1'b0;
      pend_taken_q <= 1'b0;
      wait_q       <= '0;
      err_timeout  <= 1'b0;
    end else begin
      state_q      <= state_d;
      pend_valid_q <= pend_valid_d;
      pend_taken_q <= pend_taken_d;
      wait_q       <= wait_d;
      err_timeout  <= err_d;
    end
  end

  // Next-state and raw output decode; priority mem_busy > resolve_s3 > ctrl_s2 > load_use.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves a latch behind.
    state_d      = state_q;
    pend_valid_d = pend_valid_q;
    pend_taken_d = pend_taken_q;
    wait_d       = wait_q;
    err_d        = err_timeout;
    pc_we_c      = 1'b0;
    pc_sel_c     = 1'b0;
    buf1_we_c    = 1'b0;
    bb_c         = 1'b0;
    bb2_c        = 1'b0;

    unique case (state_q)
      BRWAIT: begin
        if (mem_busy && !resolve_s3) begin
          // Frozen: nothing captured, wait counter holds.
        end else begin
          buf1_we_c = 1'b1;
          bb_c      = 1'b1;
          wait_d    = wait_q + 1'b1;
          if (resolve_s3 && mem_busy) begin
            pend_valid_d = 1'b1;
            pend_taken_d = taken_s3;
            state_d      = HOLD;
          end else if (resolve_s3) begin
            pc_we_c  = 1'b1;
            pc_sel_c = taken_s3;
            state_d  = RUN;
          end else if (wait_q == WAIT_LAST) begin
            err_d   = 1'b1;
            pc_we_c = 1'b1;
            state_d = RUN;
          end
        end
      end
      HOLD: begin
        if (!mem_busy && pend_valid_q) begin
          pc_we_c      = 1'b1;
          pc_sel_c     = pend_taken_q;
          buf1_we_c    = 1'b1;
          bb_c         = 1'b1;
          pend_valid_d = 1'b0;
          state_d      = RUN;
        end
      end
      RUN: ;
      default: state_d = RUN;
    endcase

    // RUN rules, also used for the zero-bubble exit from HOLD.
    if ((state_q == RUN) || (state_q == HOLD && !mem_busy && !pend_valid_q)) begin
      state_d = RUN;
      if (mem_busy) begin
        state_d = HOLD;
      end else if (ctrl_s2) begin
        buf1_we_c = 1'b1;
        bb_c      = 1'b1;
        wait_d    = '0;
        state_d   = BRWAIT;
      end else if (load_use) begin
        bb2_c = 1'b1;
      end else begin
        pc_we_c   = 1'b1;
        buf1_we_c = 1'b1;
      end
    end
  end

  // NOTE: outputs are gated by rst_n directly so the safe values appear as soon as reset asserts.
  assign pc_we   = rst_n & pc_we_c;
  assign pc_sel  = rst_n & pc_sel_c;
  assign buf1_we = rst_n & buf1_we_c;
  assign bb      = ~rst_n | bb_c;
  assign bb2     = ~rst_n | bb2_c;

  // Cycles in which either bubble strobe fires.
  sat_counter #(.W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (bb | bb2),
    .count (bubble_cnt)
  );

endmodule
